// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types for the cache-side memory controller: data word, RAM handshake
// state, controller FSM state and the instruction/data arbitration rule.
package cache_mem_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DATA, INSTR} memctrl_state_t;

  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int CNT_W_DEF       = 7;

  // Only one side pending wins outright; a tie goes to the side not served last.
  function automatic memctrl_state_t arb_pick(input logic           i_req,
                                              input logic           d_req,
                                              input memctrl_state_t last);
    if (d_req && !i_req) return DATA;
    if (i_req && !d_req) return INSTR;
    return (last == DATA) ? INSTR : DATA;
  endfunction

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache-to-RAM bundle. The controller takes the slave modport; the caches and
// the RAM model together sit on the master modport.
interface cache_mem_ctrl_if;
  import cache_mem_ctrl_pkg::*;

  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      err;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/cache_mem_ctrl_timeout.sv
// Per-access cycle counter: cleared between accesses, saturates at its maximum,
// and flags the final permitted wait cycle.
module cache_mem_ctrl_timeout #(
  parameter int LIMIT = 64,
  parameter int CNT_W = 7
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous and lives inside the clocked block.
  always_ff @(posedge CLK) begin
    if (RST || clear)
      cnt <= '0;
    else if (enable && cnt != CNT_MAX)
      cnt <= cnt + CNT_W'(1);
  end

  assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/cache_mem_ctrl.sv
// Responder for icache/dcache requests: arbitrates, runs one RAM access at a
// time from latched registers, and returns wait/load to the requesting cache.
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic             CLK,
  input logic             RST,
  cache_mem_ctrl_if.slave bus
);

  memctrl_state_t state, last_grant, grant;
  logic  ren_q, wen_q, err_q;
  word_t addr_q, store_q, iload_q, dload_q;
  logic  i_req, d_req, granted_req, hit, expired;

  assign i_req = bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;
  assign grant = arb_pick(i_req, d_req, last_grant);

  always_comb begin
    granted_req = 1'b0;
    case (state)
      DATA:    granted_req = d_req;
      INSTR:   granted_req = i_req;
      default: granted_req = 1'b0;
    endcase
  end

  // A dropped request gets no response even if the RAM completes this cycle.
  assign hit = granted_req && (bus.ramstate == ACCESS);

  cache_mem_ctrl_timeout #(.LIMIT(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= INSTR;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state   <= grant;
            store_q <= bus.dstore;
            if (grant == DATA) begin
              ren_q  <= ~bus.dWEN;
              wen_q  <= bus.dWEN;
              addr_q <= bus.daddr;
            end else begin
              ren_q  <= 1'b1;
              wen_q  <= 1'b0;
              addr_q <= bus.iaddr;
            end
          end
        end
        default: begin
          if (!granted_req || hit || bus.ramstate == ERROR || expired) begin
            state <= IDLE;
            ren_q <= 1'b0;
            wen_q <= 1'b0;
          end
          if (hit) begin
            last_grant <= state;
            if (state == INSTR)
              iload_q <= bus.ramload;
            else if (ren_q)
              dload_q <= bus.ramload;
          end else if (granted_req && (bus.ramstate == ERROR || expired)) begin
            err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.iwait    = ~((state == INSTR) && hit);
  assign bus.dwait    = ~((state == DATA) && hit);
  assign bus.iload    = ((state == INSTR) && hit) ? bus.ramload : iload_q;
  assign bus.dload    = ((state == DATA) && hit && ren_q) ? bus.ramload : dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: single read, stalled write, alternating
// arbitration, timeout abort, RAM error retry and reset mid-access.
module tb_cache_mem_ctrl;
  import cache_mem_ctrl_pkg::*;

  logic clk, rst;
  int   n_checks = 0;
  int   n_errors = 0;

  cache_mem_ctrl_if bus ();

  cache_mem_ctrl #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iwait"},    32'(bus.iwait),  32'd1);
    check({tag, "_dwait"},    32'(bus.dwait),  32'd1);
    check({tag, "_ramREN"},   32'(bus.ramREN), 32'd0);
    check({tag, "_ramWEN"},   32'(bus.ramWEN), 32'd0);
    check({tag, "_ramaddr"},  bus.ramaddr,     32'd0);
    check({tag, "_ramstore"}, bus.ramstore,    32'd0);
    check({tag, "_iload"},    bus.iload,       32'd0);
    check({tag, "_dload"},    bus.dload,       32'd0);
    check({tag, "_err"},      32'(bus.err),    32'd0);
  endtask

  initial begin
    idle_inputs();
    do_reset();
    #1;
    check_reset_outputs("rst");

    // 1: data read, RAM answers on the first access cycle
    bus.dREN = 1; bus.daddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    #1;
    check("t1_arb_dwait", 32'(bus.dwait), 32'd1);
    check("t1_arb_ren",   32'(bus.ramREN), 32'd0);
    cyc();
    check("t1_ren",   32'(bus.ramREN), 32'd1);
    check("t1_addr",  bus.ramaddr, 32'h40);
    check("t1_dwait", 32'(bus.dwait), 32'd0);
    check("t1_dload", bus.dload, 32'hDEADBEEF);
    cyc();
    bus.dREN = 0; bus.ramload = 32'h0; bus.ramstate = FREE;
    #1;
    check("t1_hold_dload", bus.dload, 32'hDEADBEEF);
    check("t1_idle_ren",   32'(bus.ramREN), 32'd0);

    // 2: data write, RAM BUSY for three cycles before ACCESS
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234; bus.ramstate = BUSY;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("t2_wen",   32'(bus.ramWEN), 32'd1);
      check("t2_ren",   32'(bus.ramREN), 32'd0);
      check("t2_addr",  bus.ramaddr, 32'h80);
      check("t2_store", bus.ramstore, 32'h1234);
      check("t2_dwait", 32'(bus.dwait), 32'd1);
      cyc();
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h5555;
    #1;
    check("t2_dwait_hit", 32'(bus.dwait), 32'd0);
    check("t2_dload_keep", bus.dload, 32'hDEADBEEF);
    cyc();
    bus.dWEN = 0; bus.ramstate = FREE;
    #1;
    check("t2_idle_wen", 32'(bus.ramWEN), 32'd0);

    // 3: both sides pending, RAM always ACCESS -> D, I, D, I with IDLE gaps
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h100; bus.dREN = 1; bus.daddr = 32'h200;
    bus.ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      bus.ramload = 32'h1000_0000 + 32'(k);
      #1;
      check("t3_dwait", 32'(bus.dwait), ((k % 4) == 1) ? 32'd0 : 32'd1);
      check("t3_iwait", 32'(bus.iwait), ((k % 4) == 3) ? 32'd0 : 32'd1);
      if ((k % 4) == 1) begin
        check("t3_daddr", bus.ramaddr, 32'h200);
        check("t3_dload", bus.dload, 32'h1000_0000 + 32'(k));
      end
      if ((k % 4) == 3) begin
        check("t3_iaddr", bus.ramaddr, 32'h100);
        check("t3_iload", bus.iload, 32'h1000_0000 + 32'(k));
      end
      cyc();
    end
    bus.iREN = 0; bus.dREN = 0; bus.ramload = 32'hFFFF_FFFF;
    #1;
    check("t3_hold_iload", bus.iload, 32'h1000_0007);
    check("t3_hold_dload", bus.dload, 32'h1000_0005);

    // 4: RAM stuck BUSY -> abort on the 64th access cycle
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    cyc();
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i == 62 || i == 63) begin
        check("t4_ren",   32'(bus.ramREN), 32'd1);
        check("t4_err",   32'(bus.err), 32'd0);
        check("t4_dwait", 32'(bus.dwait), 32'd1);
      end
      cyc();
    end
    check("t4_abort_err",   32'(bus.err), 32'd1);
    check("t4_abort_ren",   32'(bus.ramREN), 32'd0);
    check("t4_abort_dwait", 32'(bus.dwait), 32'd1);
    bus.dREN = 0; bus.ramstate = FREE;
    cyc();
    check("t4_err_sticky", 32'(bus.err), 32'd1);

    // 5: RAM ERROR during INSTR -> err, no response, re-grant with same iaddr
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h500; bus.ramstate = ERROR;
    cyc();
    check("t5_ren",   32'(bus.ramREN), 32'd1);
    check("t5_addr",  bus.ramaddr, 32'h500);
    check("t5_iwait", 32'(bus.iwait), 32'd1);
    check("t5_err0",  32'(bus.err), 32'd0);
    cyc();
    check("t5_err1",     32'(bus.err), 32'd1);
    check("t5_idle_ren", 32'(bus.ramREN), 32'd0);
    check("t5_idle_iw",  32'(bus.iwait), 32'd1);
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE;
    #1;
    check("t5_regrant_ren",  32'(bus.ramREN), 32'd1);
    check("t5_regrant_addr", bus.ramaddr, 32'h500);
    check("t5_iwait_hit",    32'(bus.iwait), 32'd0);
    check("t5_iload",        bus.iload, 32'hCAFE);
    cyc();
    bus.iREN = 0; bus.ramstate = FREE;
    cyc();

    // 6: reset asserted in the middle of a data access
    bus.dREN = 1; bus.daddr = 32'h600; bus.dstore = 32'h777; bus.ramstate = BUSY;
    cyc();
    check("t6_ren_before", 32'(bus.ramREN), 32'd1);
    rst = 1'b1;
    cyc();
    check_reset_outputs("t6");
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
